// File: rtl/seq_detector_prog_pkg.sv
// Shared definitions for the programmable serial pattern detector.
//   DEF_PAT_5 : reset-default 5-bit pattern (MSB is the first bit received)
//   prog_w()  : width needed to hold a prefix length of 0..pat_len
//   sat_inc() : saturating increment, capped at max
package seq_detector_prog_pkg;

  localparam logic [4:0] DEF_PAT_5 = 5'b10110;

  function automatic int unsigned prog_w(input int unsigned pat_len);
    return $clog2(pat_len + 1);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
    return (val >= max) ? max : val + 32'd1;
  endfunction

endpackage

// File: rtl/seq_detector_prog_prefix_matcher.sv
// Combinational prefix matcher: length of the longest pattern prefix that the
// newest bits of the history currently match.
//   i_hist     : received bits, newest in bit 0
//   i_pat      : pattern, MSB is the first bit of the sequence
//   i_fill     : number of valid bits in i_hist
//   o_progress : largest k <= i_fill with i_hist[k-1:0] == i_pat[MSB -: k]
module seq_detector_prog_prefix_matcher
  import seq_detector_prog_pkg::*;
#(
  parameter int unsigned PAT_LEN = 5,
  parameter int unsigned PW      = prog_w(PAT_LEN)
) (
  input  logic [PAT_LEN-1:0] i_hist,
  input  logic [PAT_LEN-1:0] i_pat,
  input  logic [PW-1:0]      i_fill,
  output logic [PW-1:0]      o_progress
);

  logic w_eq;

  // Ascending scan; a later hit overrides, so the largest matching k wins.
  always_comb begin
    o_progress = '0;
    w_eq       = 1'b0;
    for (int k = 1; k <= int'(PAT_LEN); k++) begin
      w_eq = (k <= int'(i_fill));
      for (int j = 0; j < k; j++) begin
        if (i_hist[j] != i_pat[int'(PAT_LEN) - k + j]) w_eq = 1'b0;
      end
      if (w_eq) o_progress = PW'(k);
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial bit-pattern detector with a registered (Moore) match flag.
//   clk, rst_n  : rising-edge clock, synchronous active-low reset
//   en, in      : serial bit and its valid qualifier
//   overlap     : 1 = overlapping detection, 0 = restart after each match
//   pat_load    : load pat_in (MSB first) and flush the history
//   cnt_clr     : clear match_count (wins over a coinciding match)
//   out         : match flag, held until the next accepted bit
//   progress    : matched prefix length
//   match_count : saturating count of matches
module seq_detector_prog
  import seq_detector_prog_pkg::*;
#(
  parameter int unsigned            PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0]     DEF_PAT = PAT_LEN'(DEF_PAT_5),
  parameter int unsigned            CNT_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        in,
  input  logic                        overlap,
  input  logic                        pat_load,
  input  logic [PAT_LEN-1:0]          pat_in,
  input  logic                        cnt_clr,
  output logic                        out,
  output logic [prog_w(PAT_LEN)-1:0]  progress,
  output logic [CNT_W-1:0]            match_count
);

  localparam int unsigned   PW      = prog_w(PAT_LEN);
  localparam logic [PW-1:0] FULL    = PW'(PAT_LEN);
  localparam logic [31:0]   CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [PAT_LEN-1:0] r_pat;
  logic [PAT_LEN-1:0] r_hist;
  logic [PW-1:0]      r_fill;
  logic               r_out;
  logic [CNT_W-1:0]   r_cnt;

  logic [PAT_LEN-1:0] w_hist_nxt;
  logic [PW-1:0]      w_base_fill;
  logic [PW-1:0]      w_fill_nxt;
  logic               w_out_nxt;

  // Next state for an accepted bit. In non-overlap mode a standing match
  // discards the history, so the next match needs a full fresh pattern.
  always_comb begin
    w_base_fill = (r_out && !overlap) ? '0 : r_fill;
    w_fill_nxt  = (w_base_fill >= FULL) ? FULL : w_base_fill + PW'(1);
    w_hist_nxt  = {r_hist[PAT_LEN-2:0], in};
    w_out_nxt   = (w_fill_nxt == FULL) && (w_hist_nxt == r_pat);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pat  <= DEF_PAT;
      r_hist <= '0;
      r_fill <= '0;
      r_out  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      // A load takes priority and drops this cycle's bit.
      if (pat_load) begin
        r_pat  <= pat_in;
        r_hist <= '0;
        r_fill <= '0;
        r_out  <= 1'b0;
      end else if (en) begin
        r_hist <= w_hist_nxt;
        r_fill <= w_fill_nxt;
        r_out  <= w_out_nxt;
      end

      if (cnt_clr) begin
        r_cnt <= '0;
      end else if (!pat_load && en && w_out_nxt) begin
        r_cnt <= CNT_W'(sat_inc(32'(r_cnt), CNT_MAX));
      end
    end
  end

  seq_detector_prog_prefix_matcher #(
    .PAT_LEN (PAT_LEN),
    .PW      (PW)
  ) u_prefix_matcher (
    .i_hist     (r_hist),
    .i_pat      (r_pat),
    .i_fill     (r_fill),
    .o_progress (progress)
  );

  assign out         = r_out;
  assign match_count = r_cnt;

endmodule

// File: tb/tb_seq_detector_prog.sv
module tb_seq_detector_prog;

  localparam int unsigned PAT_LEN = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       t_rst_n, t_en, t_in, t_overlap, t_pat_load, t_cnt_clr;
  logic [4:0] t_pat_in;
  logic       out8, out2;
  logic [2:0] prog8, prog2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  seq_detector_prog #(.PAT_LEN(5), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(t_rst_n), .en(t_en), .in(t_in), .overlap(t_overlap),
    .pat_load(t_pat_load), .pat_in(t_pat_in), .cnt_clr(t_cnt_clr),
    .out(out8), .progress(prog8), .match_count(cnt8)
  );

  seq_detector_prog #(.PAT_LEN(5), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(t_rst_n), .en(t_en), .in(t_in), .overlap(t_overlap),
    .pat_load(t_pat_load), .pat_in(t_pat_in), .cnt_clr(t_cnt_clr),
    .out(out2), .progress(prog2), .match_count(cnt2)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: the bits received since the last restart, oldest first.
  bit         m_q[$];
  logic [4:0] m_pat;
  bit         m_out;
  int         m_cnt8, m_cnt2;

  function automatic int model_prog();
    int n;
    bit ok;
    n = m_q.size();
    for (int k = n; k > 0; k--) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) if (m_q[n-k+j] != m_pat[PAT_LEN-1-j]) ok = 1'b0;
      if (ok) return k;
    end
    return 0;
  endfunction

  task automatic model_edge();
    bit hit;
    hit = 1'b0;
    if (!t_rst_n) begin
      m_pat = 5'b10110; m_q.delete(); m_out = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      if (t_pat_load) begin
        m_pat = t_pat_in; m_q.delete(); m_out = 1'b0;
      end else if (t_en) begin
        if (m_out && !t_overlap) m_q.delete();
        m_q.push_back(t_in);
        if (m_q.size() > PAT_LEN) void'(m_q.pop_front());
        m_out = (m_q.size() == PAT_LEN) && (model_prog() == PAT_LEN);
        hit   = m_out;
      end
      if (t_cnt_clr) begin
        m_cnt8 = 0; m_cnt2 = 0;
      end else if (hit) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  endtask

  task automatic drive(input logic rst_n, input logic en, input logic in_b, input logic ov,
                       input logic ld, input logic [4:0] pat, input logic clr);
    t_rst_n = rst_n; t_en = en; t_in = in_b; t_overlap = ov;
    t_pat_load = ld; t_pat_in = pat; t_cnt_clr = clr;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic       rst_n, en, in_b, ov, ld;
    logic [4:0] pat;
    logic       clr;
    logic       e_out;
    int         e_prog, e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_n, input logic en, input logic in_b, input logic ov,
                     input logic ld, input logic [4:0] pat, input logic clr,
                     input logic e_out, input int e_prog, input int e_cnt);
    vec_t v;
    v.rst_n = rst_n; v.en = en; v.in_b = in_b; v.ov = ov; v.ld = ld; v.pat = pat;
    v.clr = clr; v.e_out = e_out; v.e_prog = e_prog; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  logic [4:0] p10110;
  int         exp_c2;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

    // rst  en in ov ld pat    clr   out prog cnt
    // Reset with en=1 and toggling input.
    add(0, 1, 1, 0, 0, 5'd0, 0,  0, 0, 0);
    add(0, 1, 0, 0, 0, 5'd0, 0,  0, 0, 0);
    // Overlapping detection of 10110 in 10110110.
    add(1, 1, 1, 1, 0, 5'd0, 0,  0, 1, 0);
    add(1, 1, 0, 1, 0, 5'd0, 0,  0, 2, 0);
    add(1, 1, 1, 1, 0, 5'd0, 0,  0, 3, 0);
    add(1, 1, 1, 1, 0, 5'd0, 0,  0, 4, 0);
    add(1, 1, 0, 1, 0, 5'd0, 0,  1, 5, 1);
    add(1, 1, 1, 1, 0, 5'd0, 0,  0, 3, 1);
    add(1, 1, 1, 1, 0, 5'd0, 0,  0, 4, 1);
    add(1, 1, 0, 1, 0, 5'd0, 0,  1, 5, 2);
    add(0, 1, 1, 0, 0, 5'd0, 0,  0, 0, 0);
    // Non-overlapping: same stream, one match.
    add(1, 1, 1, 0, 0, 5'd0, 0,  0, 1, 0);
    add(1, 1, 0, 0, 0, 5'd0, 0,  0, 2, 0);
    add(1, 1, 1, 0, 0, 5'd0, 0,  0, 3, 0);
    add(1, 1, 1, 0, 0, 5'd0, 0,  0, 4, 0);
    add(1, 1, 0, 0, 0, 5'd0, 0,  1, 5, 1);
    add(1, 1, 1, 0, 0, 5'd0, 0,  0, 1, 1);
    add(1, 1, 1, 0, 0, 5'd0, 0,  0, 1, 1);
    add(1, 1, 0, 0, 0, 5'd0, 0,  0, 2, 1);
    add(0, 1, 1, 0, 0, 5'd0, 0,  0, 0, 0);
    // en gaps inside the pattern and after the match.
    add(1, 1, 1, 0, 0, 5'd0, 0,  0, 1, 0);
    add(1, 1, 0, 0, 0, 5'd0, 0,  0, 2, 0);
    add(1, 0, 1, 0, 0, 5'd0, 0,  0, 2, 0);
    add(1, 1, 1, 0, 0, 5'd0, 0,  0, 3, 0);
    add(1, 0, 0, 0, 0, 5'd0, 0,  0, 3, 0);
    add(1, 0, 1, 0, 0, 5'd0, 0,  0, 3, 0);
    add(1, 1, 1, 0, 0, 5'd0, 0,  0, 4, 0);
    add(1, 1, 0, 0, 0, 5'd0, 0,  1, 5, 1);
    add(1, 0, 1, 0, 0, 5'd0, 0,  1, 5, 1);
    add(1, 0, 0, 0, 0, 5'd0, 0,  1, 5, 1);
    add(1, 1, 1, 0, 0, 5'd0, 0,  0, 1, 1);
    add(1, 1, 0, 0, 0, 5'd0, 0,  0, 2, 1);
    // Load 11100 with en=1: this cycle's bit is dropped.
    add(1, 1, 1, 0, 1, 5'b11100, 0,  0, 0, 1);
    add(1, 1, 1, 0, 0, 5'd0, 0,  0, 1, 1);
    add(1, 1, 1, 0, 0, 5'd0, 0,  0, 2, 1);
    add(1, 1, 1, 0, 0, 5'd0, 0,  0, 3, 1);
    add(1, 1, 0, 0, 0, 5'd0, 0,  0, 4, 1);
    add(1, 1, 0, 0, 0, 5'd0, 0,  1, 5, 2);
    // Clear while idle; the flag holds.
    add(1, 0, 0, 0, 0, 5'd0, 1,  1, 5, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].en, vecs[i].in_b, vecs[i].ov, vecs[i].ld, vecs[i].pat,
            vecs[i].clr);
      cycle();
      exp_c2 = (vecs[i].e_cnt > 3) ? 3 : vecs[i].e_cnt;
      chk($sformatf("tbl%0d out", i), int'(out8), int'(vecs[i].e_out));
      chk($sformatf("tbl%0d progress", i), int'(prog8), vecs[i].e_prog);
      chk($sformatf("tbl%0d count", i), int'(cnt8), vecs[i].e_cnt);
      chk($sformatf("tbl%0d count_w2", i), int'(cnt2), exp_c2);
    end

    // Saturation of the 2-bit counter, clear against a match, reset mid-pattern.
    p10110 = 5'b10110;
    drive(0, 0, 0, 0, 0, 5'd0, 0);
    cycle();
    for (int r = 0; r < 5; r++) begin
      for (int b = 0; b < 5; b++) begin
        drive(1, 1, p10110[4-b], 0, 0, 5'd0, 0);
        cycle();
      end
      chk($sformatf("sat%0d out", r), int'(out2), 1);
      chk($sformatf("sat%0d count_w2", r), int'(cnt2), (r + 1 > 3) ? 3 : r + 1);
      chk($sformatf("sat%0d count", r), int'(cnt8), r + 1);
    end
    for (int b = 0; b < 5; b++) begin
      drive(1, 1, p10110[4-b], 0, 0, 5'd0, (b == 4) ? 1'b1 : 1'b0);
      cycle();
    end
    chk("clr_vs_match out", int'(out2), 1);
    chk("clr_vs_match count_w2", int'(cnt2), 0);
    chk("clr_vs_match count", int'(cnt8), 0);
    drive(1, 1, 1, 0, 0, 5'd0, 0);
    cycle();
    drive(1, 1, 0, 0, 0, 5'd0, 0);
    cycle();
    chk("mid progress", int'(prog2), 2);
    drive(0, 1, 1, 1, 0, 5'd0, 0);
    cycle();
    chk("midrst out", int'(out2), 0);
    chk("midrst progress", int'(prog2), 0);
    chk("midrst count", int'(cnt8), 0);

    // Random stream against the reference model.
    drive(0, 0, 0, 0, 0, 5'd0, 0);
    cycle();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)),
            (i % 400 < 200) ? 1'($urandom_range(0, 1)) : t_overlap,
            ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
            5'($urandom_range(1, 30)),
            ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
      cycle();
      chk("rnd out", int'(out8), int'(m_out));
      chk("rnd progress", int'(prog8), model_prog());
      chk("rnd count", int'(cnt8), m_cnt8);
      chk("rnd out_w2", int'(out2), int'(m_out));
      chk("rnd count_w2", int'(cnt2), m_cnt2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
